// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: turns a load/store into a
// single-beat bus transaction, stalls the pipeline while it is in flight and
// returns the size/sign-extended load result in a register.
//
// state | meaning
// IDLE  | no transaction; decode the MEM-stage instruction, flag faults
// REQ   | bus request held with stable outputs until dmem_ready
// DONE  | result available, pipeline released for exactly one cycle
module mem_access_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic [2:0]      funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic            FlushM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] ReadDataM,
   output logic            StallM,
   output logic            MisalignM
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t          state_q, state_d;
   logic            bad_f3, bad_align, fault, access;
   logic            capture, load_rd;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_wstrb;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_ext;

   // Fault decode: illegal size encodings for the access direction and misalignment.
   always_comb begin
      bad_f3 = 1'b0;
      if (MemReadM)
         bad_f3 = (funct3M == 3'b011) || (funct3M == 3'b110) || (funct3M == 3'b111);
      else if (MemWriteM)
         bad_f3 = (funct3M > 3'b010);
      bad_align = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                  ((funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
      fault  = (MemReadM & MemWriteM) | bad_f3 | bad_align;
      access = (MemReadM ^ MemWriteM) & ~FlushM & ~fault;
   end

   // Store lane placement: replicate the datum across the word, strobe the target lanes.
   always_comb begin
      st_wdata = WriteDataM;
      st_wstrb = 4'b1111;
      case (funct3M[1:0])
         2'b00: begin
            st_wdata = {4{WriteDataM[7:0]}};
            st_wstrb = 4'b0001 << ALUResultM[1:0];
         end
         2'b01: begin
            st_wdata = {2{WriteDataM[15:0]}};
            st_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // Load extraction from the returned word using the offset/size captured at issue.
   always_comb begin
      case (off_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'b0, ld_byte};
         3'b101:  ld_ext = {16'b0, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   // Next-state and control outputs; stall/fault flags are suppressed during reset.
   always_comb begin
      state_d   = state_q;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      dmem_req  = 1'b0;
      capture   = 1'b0;
      load_rd   = 1'b0;
      case (state_q)
         IDLE: begin
            MisalignM = fault & (MemReadM | MemWriteM) & ~FlushM;
            if (access) begin
               StallM  = 1'b1;
               capture = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            dmem_req = 1'b1;
            StallM   = 1'b1;
            if (dmem_ready) begin
               load_rd = ~dmem_we;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset) begin
         StallM    = 1'b0;
         MisalignM = 1'b0;
      end
   end

   // State, captured bus outputs and the load result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= 4'b0;
         off_q      <= 2'b0;
         f3_q       <= 3'b0;
         ReadDataM  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
            dmem_wdata <= st_wdata;
            dmem_wstrb <= st_wstrb;
            off_q      <= ALUResultM[1:0];
            f3_q       <= funct3M;
         end
         if (load_rd)
            ReadDataM <= ld_ext;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random loads/stores
// against an arithmetic model of lane placement, extension and fault rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM, FlushM, dmem_ready;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM, dmem_rdata;
   logic        dmem_req, dmem_we, StallM, MisalignM;
   logic [31:0] dmem_addr, dmem_wdata, ReadDataM;
   logic [3:0]  dmem_wstrb;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rd = 32'h0;

   mem_access_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .FlushM(FlushM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_fault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
      int sz;
      if (rd && wr) return 1'b1;
      if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
      if (wr && f3 > 2) return 1'b1;
      sz = int'(f3) % 4;
      if (sz == 1 && a % 2 != 0) return 1'b1;
      if (sz == 2 && a % 4 != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * (a % 4))) & 32'hFF;
      h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      case (f3)
         3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd4: return b;
         3'd5: return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
      if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] model_wstrb(logic [2:0] f3, logic [31:0] a);
      if (f3 == 0) return 32'(1) << (a % 4);
      if (f3 == 1) return ((a % 4) >= 2) ? 32'hC : 32'h3;
      return 32'hF;
   endfunction

   task automatic clear_inputs();
      MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b0; funct3M = 3'b0;
      ALUResultM = 32'h0; WriteDataM = 32'h0; dmem_ready = 1'b0;
   endtask

   // One MEM-stage instruction from IDLE to the cycle after DONE.
   task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit flush,
                          input int delay, input logic [31:0] rdata, input bit flush_in_req);
      bit flt, acc;
      int stalls, reqs;
      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a;
      WriteDataM = wd; FlushM = flush; dmem_ready = 1'b0; dmem_rdata = $urandom;
      flt = (rd || wr) ? model_fault(rd, wr, f3, a) : 1'b0;
      acc = (rd != wr) && !flush && !flt;
      #1;
      chk("misalign_idle", {31'b0, MisalignM}, {31'b0, flt && (rd || wr) && !flush});
      chk("stall_idle", {31'b0, StallM}, {31'b0, acc});
      chk("req_idle", {31'b0, dmem_req}, 32'h0);
      if (!acc) begin
         @(negedge clk);
         chk("req_noacc", {31'b0, dmem_req}, 32'h0);
         chk("stall_noacc", {31'b0, StallM}, 32'h0);
         clear_inputs();
         return;
      end
      stalls = 1;
      reqs = 0;
      for (int c = 0; c <= delay; c++) begin
         @(negedge clk);
         if (flush_in_req) FlushM = 1'b1;
         #1;
         chk("req_high", {31'b0, dmem_req}, 32'h1);
         chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
         chk("we", {31'b0, dmem_we}, {31'b0, wr});
         chk("misalign_req", {31'b0, MisalignM}, 32'h0);
         if (wr) begin
            chk("wdata", dmem_wdata, model_wdata(f3, wd));
            chk("wstrb", {28'b0, dmem_wstrb}, model_wstrb(f3, a));
         end
         if (StallM) stalls++;
         if (dmem_req) reqs++;
         dmem_ready = (c == delay);
         dmem_rdata = (c == delay) ? rdata : $urandom;
      end
      @(negedge clk);
      if (rd) exp_rd = model_load(f3, a, rdata);
      chk("req_done", {31'b0, dmem_req}, 32'h0);
      chk("stall_done", {31'b0, StallM}, 32'h0);
      chk("rdata", ReadDataM, exp_rd);
      chk("stall_cycles", stalls, delay + 2);
      chk("req_cycles", reqs, delay + 1);
      clear_inputs();
      dmem_rdata = $urandom;
   endtask

   initial begin
      int r;
      bit rd, wr, fl;
      logic [2:0]  f3;
      logic [31:0] a;
      clear_inputs();
      dmem_rdata = 32'h0;
      reset = 1'b1;
      MemReadM = 1'b1; ALUResultM = 32'h101; funct3M = 3'b010;
      repeat (2) @(negedge clk);
      chk("rst_misalign", {31'b0, MisalignM}, 32'h0);
      chk("rst_stall", {31'b0, StallM}, 32'h0);
      chk("rst_req", {31'b0, dmem_req}, 32'h0);
      chk("rst_we", {31'b0, dmem_we}, 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_wstrb", {28'b0, dmem_wstrb}, 32'h0);
      chk("rst_rdata", ReadDataM, 32'h0);
      clear_inputs();
      reset = 1'b0;

      run_txn(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0);
      chk("lw_result", ReadDataM, 32'hDEADBEEF);
      run_txn(1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h80112233, 0);
      chk("lb_result", ReadDataM, 32'hFFFFFF80);
      run_txn(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80112233, 0);
      chk("lbu_result", ReadDataM, 32'h00000080);
      run_txn(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 3, 32'h0, 0);
      chk("sh_keeps_rdata", ReadDataM, 32'h00000080);
      run_txn(1, 0, 3'b010, 32'h101, 0, 0, 0, 32'h0, 0);
      run_txn(0, 1, 3'b000, 32'h300, 32'h5A, 1, 0, 32'h0, 0);
      run_txn(0, 1, 3'b000, 32'h300, 32'h5A, 0, 2, 32'h0, 1);
      run_txn(1, 0, 3'b101, 32'h202, 0, 0, 1, 32'h9876F00D, 0);
      run_txn(1, 0, 3'b001, 32'h200, 0, 0, 0, 32'h12348001, 0);

      // Reset pulsed while a load waits in REQ.
      @(negedge clk);
      MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h400;
      @(negedge clk);
      chk("pre_rst_req", {31'b0, dmem_req}, 32'h1);
      reset = 1'b1; dmem_ready = 1'b0; ALUResultM = 32'h401;
      @(negedge clk);
      chk("rst_req_abort", {31'b0, dmem_req}, 32'h0);
      chk("rst_req_rdata", ReadDataM, 32'h0);
      chk("rst_req_stall", {31'b0, StallM}, 32'h0);
      chk("rst_req_misalign", {31'b0, MisalignM}, 32'h0);
      exp_rd = 32'h0;
      reset = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk("post_rst_idle", {31'b0, dmem_req}, 32'h0);

      for (int i = 0; i < 80; i++) begin
         r  = $urandom_range(0, 9);
         rd = (r <= 3) || (r == 8);
         wr = (r >= 4 && r <= 8);
         fl = ($urandom_range(0, 7) == 0);
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0 && rd && !wr) f3 = 3'b100 | 3'($urandom_range(0, 1));
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         run_txn(rd, wr, f3, a, $urandom, fl, $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 4) == 0);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
